display_scan: RTL and testbench

- Parametrised time-multiplexed seven-segment scan controller for the board display; successor to the static nibble selector.
- Latches a packed hex word on a load strobe and rotates through DIGITS positions at a programmable rate.
- Per position it drives a one-hot anode select, decoded segments and a decimal point.
- Per-digit enable mask and optional leading-zero blanking; sits between CPU debug/IO registers and the board pins.

---
 rtl/display_scan.sv | 157 +++++++++++++++
 tb/tb_display_scan.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/display_scan.sv
// Time-multiplexed seven-segment scan controller. It latches a packed hex word and rotates through DIGITS positions.
// Optional leading-zero blanking is enabled by defining DISP_LZB_EN.
module display_scan #(
  parameter int DIGITS     = 8,
  parameter int SCAN_DIV   = 100000,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic                                         load,
  input  logic [4*DIGITS-1:0]                          dig_in,
  input  logic [DIGITS-1:0]                            dp_in,
  input  logic [DIGITS-1:0]                            digit_en,
  output logic [DIGITS-1:0]                            an,
  output logic [6:0]                                   seg,
  output logic                                         dp,
  output logic [((DIGITS > 1) ? $clog2(DIGITS) : 1)-1:0] num
);

  localparam int NW  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int PW  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam bit POL = (ACTIVE_LOW != 0);

  logic [4*DIGITS-1:0] sh_dig_q, sh_dig_d;
  logic [DIGITS-1:0]   sh_dp_q, sh_dp_d;
  logic [DIGITS-1:0]   sh_en_q, sh_en_d;
  logic [PW-1:0]       presc_q, presc_d;
  logic [NW-1:0]       num_q, num_d;
  logic [DIGITS-1:0]   an_q, an_d;
  logic [6:0]          seg_q, seg_d;
  logic                dp_q, dp_d;

  logic [3:0]          nib;
  logic                dp_sel, en_sel, show;
  logic [DIGITS-1:0]   an_hi;
  logic [6:0]          seg_hi;

  // Table is stored active-low, {g,f,e,d,c,b,a}.
  function automatic logic [6:0] hex_lo(input logic [3:0] h);
    case (h)
      4'h0: hex_lo = 7'b1000000;
      4'h1: hex_lo = 7'b1111001;
      4'h2: hex_lo = 7'b0100100;
      4'h3: hex_lo = 7'b0110000;
      4'h4: hex_lo = 7'b0011001;
      4'h5: hex_lo = 7'b0010010;
      4'h6: hex_lo = 7'b0000010;
      4'h7: hex_lo = 7'b1111000;
      4'h8: hex_lo = 7'b0000000;
      4'h9: hex_lo = 7'b0010000;
      4'hA: hex_lo = 7'b0001000;
      4'hB: hex_lo = 7'b0000011;
      4'hC: hex_lo = 7'b1000110;
      4'hD: hex_lo = 7'b0100001;
      4'hE: hex_lo = 7'b0000110;
      default: hex_lo = 7'b0001110;
    endcase
  endfunction

`ifdef DISP_LZB_EN
  logic [DIGITS-1:0] blank;
  logic              blank_sel;

  // A digit is blanked when it and every higher digit are zero and none of them has a point.
  always_comb begin
    logic run;
    run   = 1'b1;
    blank = '0;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      run      = run & (sh_dig_q[4*k +: 4] == 4'h0) & ~sh_dp_q[k];
      blank[k] = run;
    end
  end
`endif

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can leave it unassigned and infer a latch.
    sh_dig_d = sh_dig_q;
    sh_dp_d  = sh_dp_q;
    sh_en_d  = sh_en_q;
    if (load) begin
      sh_dig_d = dig_in;
      sh_dp_d  = dp_in;
      sh_en_d  = digit_en;
    end

    presc_d = presc_q + PW'(1);
    num_d   = num_q;
    if (presc_q == PW'(SCAN_DIV - 1)) begin
      presc_d = '0;
      num_d   = (num_q == NW'(DIGITS - 1)) ? '0 : num_q + NW'(1);
    end

    nib    = '0;
    dp_sel = 1'b0;
    en_sel = 1'b0;
`ifdef DISP_LZB_EN
    blank_sel = 1'b0;
`endif
    for (int k = 0; k < DIGITS; k++) begin
      if (num_q == NW'(k)) begin
        nib    = sh_dig_q[4*k +: 4];
        dp_sel = sh_dp_q[k];
        en_sel = sh_en_q[k];
`ifdef DISP_LZB_EN
        blank_sel = blank[k];
`endif
      end
    end

`ifdef DISP_LZB_EN
    show = en_sel & ~blank_sel;
`else
    show = en_sel;
`endif

    an_hi = '0;
    for (int k = 0; k < DIGITS; k++) begin
      an_hi[k] = show & (num_q == NW'(k));
    end
    seg_hi = show ? ~hex_lo(nib) : 7'h00;

    an_d  = an_hi ^ {DIGITS{POL}};
    seg_d = seg_hi ^ {7{POL}};
    dp_d  = (show & dp_sel) ^ POL;
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples the pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: the shadow word is a handful of flops, not a RAM, so it is reset along with the rest of the state.
      sh_dig_q <= '0;
      sh_dp_q  <= '0;
      sh_en_q  <= '0;
      presc_q  <= '0;
      num_q    <= '0;
      an_q     <= {DIGITS{POL}};
      seg_q    <= {7{POL}};
      dp_q     <= POL;
    end else begin
      sh_dig_q <= sh_dig_d;
      sh_dp_q  <= sh_dp_d;
      sh_en_q  <= sh_en_d;
      presc_q  <= presc_d;
      num_q    <= num_d;
      an_q     <= an_d;
      seg_q    <= seg_d;
      dp_q     <= dp_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;
  assign num = num_q;

endmodule

// File: tb/tb_display_scan.sv
// Bench for display_scan: two instances (8 digits, active-low; 5 digits, active-high) are checked every cycle against an arithmetic model.
// Compile with DISP_LZB_EN to exercise leading-zero blanking.
module tb_display_scan;

  localparam int DA = 8, SA = 4;
  localparam int DB = 5, SB = 3;

  typedef struct packed {
    logic [15:0] an;
    logic [6:0]  seg;
    logic        dp;
  } out_t;

  logic        clk = 1'b0;
  logic        rst_n, load;
  logic [31:0] dig_in;
  logic [7:0]  dp_in, digit_en;

  logic [7:0]  an_a;
  logic [6:0]  seg_a;
  logic        dp_a;
  logic [2:0]  num_a;
  logic [4:0]  an_b;
  logic [6:0]  seg_b;
  logic        dp_b;
  logic [2:0]  num_b;

  display_scan #(.DIGITS(DA), .SCAN_DIV(SA), .ACTIVE_LOW(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .load(load), .dig_in(dig_in), .dp_in(dp_in),
    .digit_en(digit_en), .an(an_a), .seg(seg_a), .dp(dp_a), .num(num_a)
  );

  display_scan #(.DIGITS(DB), .SCAN_DIV(SB), .ACTIVE_LOW(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .load(load), .dig_in(dig_in[19:0]), .dp_in(dp_in[4:0]),
    .digit_en(digit_en[4:0]), .an(an_b), .seg(seg_b), .dp(dp_b), .num(num_b)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Segment patterns, active-low, {g,f,e,d,c,b,a}.
  logic [6:0] hex_lo [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                              7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                              7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                              7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  // Model state: shadow word plus the number of run cycles since reset.
  logic [31:0] m_dig;
  logic [7:0]  m_dp, m_en;
  int          ticks;
  out_t        exp_a, exp_b;
  int          exp_num_a, exp_num_b;
  bit          model_valid = 1'b0;

  function automatic out_t inactive(input bit al);
    out_t o;
    o.an  = al ? 16'hFFFF : 16'h0000;
    o.seg = al ? 7'h7F : 7'h00;
    o.dp  = al;
    return o;
  endfunction

  function automatic out_t exp_out(input int d, input bit al, input int n);
    out_t    o;
    bit      show;
    longint  dig_m, dp_m;
    dig_m = longint'(m_dig) & ((64'd1 << (4 * d)) - 1);
    dp_m  = longint'(m_dp) & ((64'd1 << d) - 1);
    show  = m_en[n];
`ifdef DISP_LZB_EN
    if (n > 0 && (dig_m >> (4 * n)) == 0 && (dp_m >> n) == 0) show = 1'b0;
`endif
    o = '0;
    if (show) begin
      o.an[n] = 1'b1;
      o.seg   = ~hex_lo[(dig_m >> (4 * n)) & 64'hF];
      o.dp    = m_dp[n];
    end
    if (al) begin
      o.an  = ~o.an;
      o.seg = ~o.seg;
      o.dp  = ~o.dp;
    end
    return o;
  endfunction

  always @(posedge clk) begin
    model_valid <= 1'b1;
    if (!rst_n) begin
      m_dig     <= '0;
      m_dp      <= '0;
      m_en      <= '0;
      ticks     <= 0;
      exp_a     <= inactive(1'b1);
      exp_b     <= inactive(1'b0);
      exp_num_a <= 0;
      exp_num_b <= 0;
    end else begin
      exp_a     <= exp_out(DA, 1'b1, (ticks / SA) % DA);
      exp_b     <= exp_out(DB, 1'b0, (ticks / SB) % DB);
      exp_num_a <= ((ticks + 1) / SA) % DA;
      exp_num_b <= ((ticks + 1) / SB) % DB;
      ticks     <= ticks + 1;
      if (load) begin
        m_dig <= dig_in;
        m_dp  <= dp_in;
        m_en  <= digit_en;
      end
    end
  end

  always @(negedge clk) begin
    if (model_valid) begin
      check("an_a", 16'(an_a), 16'(exp_a.an[7:0]));
      check("seg_a", 16'(seg_a), 16'(exp_a.seg));
      check("dp_a", 16'(dp_a), 16'(exp_a.dp));
      check("num_a", 16'(num_a), 16'(exp_num_a));
      check("an_b", 16'(an_b), 16'(exp_b.an[4:0]));
      check("seg_b", 16'(seg_b), 16'(exp_b.seg));
      check("dp_b", 16'(dp_b), 16'(exp_b.dp));
      check("num_b", 16'(num_b), 16'(exp_num_b));
    end
  end

  task automatic load_word(input logic [31:0] w, input logic [7:0] p, input logic [7:0] e);
    @(negedge clk);
    load = 1'b1; dig_in = w; dp_in = p; digit_en = e;
    @(negedge clk);
    load = 1'b0;
  endtask

  initial begin
    bit found;
    int k;
    logic [31:0] v;

    rst_n = 1'b0; load = 1'b0; dig_in = '0; dp_in = '0; digit_en = '0;
    repeat (3) @(negedge clk);
    check("rst_an_a", 16'(an_a), 16'hFF);
    check("rst_seg_a", 16'(seg_a), 16'h7F);
    check("rst_dp_a", 16'(dp_a), 16'h1);
    check("rst_num_a", 16'(num_a), 16'h0);
    check("rst_an_b", 16'(an_b), 16'h00);
    check("rst_seg_b", 16'(seg_b), 16'h00);

    // Release reset with a load on the first run edge.
    rst_n = 1'b1; load = 1'b1; dig_in = 32'h76543210; dp_in = 8'h00; digit_en = 8'hFF;
    @(negedge clk); load = 1'b0;
    @(negedge clk);
    check("first_an_a", 16'(an_a), 16'hFE);
    check("first_seg_a", 16'(seg_a), 16'h40);
    check("first_an_b", 16'(an_b), 16'h01);
    check("first_seg_b", 16'(seg_b), 16'h3F);
    repeat (2) @(negedge clk);
    check("adv_num_a", 16'(num_a), 16'h1);
    @(negedge clk);
    check("adv_an_a", 16'(an_a), 16'hFD);
    check("adv_seg_a", 16'(seg_a), 16'h79);
    repeat (40) @(negedge clk);

    load_word(32'h76543210, 8'h02, 8'h0F);
    repeat (40) @(negedge clk);

    // Load on the same edge that wraps num from 7 to 0.
    found = 1'b0;
    for (int g = 0; g < 100 && !found; g++) begin
      @(negedge clk);
      if (ticks % SA == SA - 1 && (ticks / SA) % DA == DA - 1) found = 1'b1;
    end
    check("collision_wait", 16'(found), 16'h1);
    load = 1'b1; dig_in = 32'h0000000F; dp_in = 8'h00; digit_en = 8'hFF;
    @(negedge clk); load = 1'b0;
    @(negedge clk);
    check("collision_an_a", 16'(an_a), 16'hFE);
    check("collision_seg_a", 16'(seg_a), 16'h0E);

    // Reset while the 5-digit instance shows digit 3.
    found = 1'b0;
    for (int g = 0; g < 100 && !found; g++) begin
      @(negedge clk);
      if ((ticks / SB) % DB == 3) found = 1'b1;
    end
    check("midscan_wait", 16'(found), 16'h1);
    rst_n = 1'b0;
    @(negedge clk);
    check("midscan_num_b", 16'(num_b), 16'h0);
    check("midscan_an_b", 16'(an_b), 16'h00);
    check("midscan_seg_b", 16'(seg_b), 16'h00);
    check("midscan_dp_b", 16'(dp_b), 16'h0);
    rst_n = 1'b1;

    load_word(32'h00000A05, 8'h00, 8'hFF);
    repeat (40) @(negedge clk);
    load_word(32'h00300000, 8'h20, 8'hFF);
    repeat (40) @(negedge clk);

    repeat (3000) begin
      @(negedge clk);
      rst_n = ($urandom_range(0, 299) != 0);
      load  = ($urandom_range(0, 7) == 0);
      k = $urandom_range(0, 8);
      v = $urandom;
      if (k > 0) v = v & (32'hFFFF_FFFF >> (4 * k));
      dig_in   = v;
      dp_in    = ($urandom_range(0, 3) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h00;
      digit_en = ($urandom_range(0, 1) == 1) ? 8'hFF : 8'($urandom);
    end

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
